// File: rtl/micro_sequencer.sv
// Control-store address sequencer: picks the next microinstruction address from the MIR
// condition/jump fields, PSR flags and IR, stalls on memory, and halts only at the fetch boundary.
module micro_sequencer #(
  parameter int          DATAWIDTH_JUMPADDRESS = 11,
  parameter int          DATAWIDTH_CONDITION   = 3,
  parameter int          DATAWIDTH_COUNTER     = 16,
  parameter int unsigned FETCH_ADDRESS         = 0
) (
  input  logic                             MICRO_SEQUENCER_CLOCK_50,
  input  logic                             MICRO_SEQUENCER_ResetInLow_In,
  input  logic                             MICRO_SEQUENCER_Run_In,
  input  logic [DATAWIDTH_CONDITION-1:0]   MICRO_SEQUENCER_Condition_InBus,
  input  logic [DATAWIDTH_JUMPADDRESS-1:0] MICRO_SEQUENCER_JumpAddress_InBus,
  input  logic                             MICRO_SEQUENCER_RD_In,
  input  logic                             MICRO_SEQUENCER_WR_In,
  input  logic                             MICRO_SEQUENCER_MemReady_In,
  input  logic [3:0]                       MICRO_SEQUENCER_Flags_InBus,
  input  logic [31:0]                      MICRO_SEQUENCER_IR_InBus,
  output logic [DATAWIDTH_JUMPADDRESS-1:0] MICRO_SEQUENCER_CSAddress_OutBus,
  output logic [1:0]                       MICRO_SEQUENCER_State_OutBus,
  output logic                             MICRO_SEQUENCER_Busy_Out,
  output logic [DATAWIDTH_COUNTER-1:0]     MICRO_SEQUENCER_uCycleCount_OutBus,
  output logic [DATAWIDTH_COUNTER-1:0]     MICRO_SEQUENCER_InstrCount_OutBus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_WAITMEM = 2'b10
  } state_t;

  localparam logic [DATAWIDTH_JUMPADDRESS-1:0] FETCH = DATAWIDTH_JUMPADDRESS'(FETCH_ADDRESS);
  localparam logic [DATAWIDTH_COUNTER-1:0]     CNT_MAX = '1;
  localparam logic [DATAWIDTH_CONDITION-1:0]   COND_DECODE = '1;

  state_t                           state_q;
  logic                             busy_q;
  logic [DATAWIDTH_JUMPADDRESS-1:0] addr_q;
  logic [DATAWIDTH_JUMPADDRESS-1:0] next_addr_d;
  logic [DATAWIDTH_COUNTER-1:0]     ucnt_q;
  logic [DATAWIDTH_COUNTER-1:0]     icnt_q;
  logic                             take_jump;
  logic                             is_decode;
  logic                             mem_stall;

  // Only the op, op3 and i fields of the IR steer the sequencer.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{MICRO_SEQUENCER_IR_InBus[29:25], MICRO_SEQUENCER_IR_InBus[18:14],
                            MICRO_SEQUENCER_IR_InBus[12:0]};

  assign is_decode = (MICRO_SEQUENCER_Condition_InBus == COND_DECODE);
  assign mem_stall = (MICRO_SEQUENCER_RD_In | MICRO_SEQUENCER_WR_In) & ~MICRO_SEQUENCER_MemReady_In;

  always_comb begin
    take_jump = 1'b0;
    case (MICRO_SEQUENCER_Condition_InBus)
      3'd1:    take_jump = MICRO_SEQUENCER_Flags_InBus[3];
      3'd2:    take_jump = MICRO_SEQUENCER_Flags_InBus[2];
      3'd3:    take_jump = MICRO_SEQUENCER_Flags_InBus[1];
      3'd4:    take_jump = MICRO_SEQUENCER_Flags_InBus[0];
      3'd5:    take_jump = MICRO_SEQUENCER_IR_InBus[13];
      3'd6:    take_jump = 1'b1;
      default: take_jump = 1'b0;
    endcase

    if (is_decode) begin
      next_addr_d = DATAWIDTH_JUMPADDRESS'({1'b1, MICRO_SEQUENCER_IR_InBus[31:30],
                                            MICRO_SEQUENCER_IR_InBus[24:19], 2'b00});
    end else if (take_jump) begin
      next_addr_d = MICRO_SEQUENCER_JumpAddress_InBus;
    end else begin
      next_addr_d = addr_q + DATAWIDTH_JUMPADDRESS'(1);
    end
  end

  always_ff @(posedge MICRO_SEQUENCER_CLOCK_50 or negedge MICRO_SEQUENCER_ResetInLow_In) begin
    if (!MICRO_SEQUENCER_ResetInLow_In) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      addr_q  <= FETCH;
      ucnt_q  <= '0;
      icnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          addr_q <= FETCH;
          if (MICRO_SEQUENCER_Run_In) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (mem_stall) begin
            state_q <= ST_WAITMEM;
          end else begin
            addr_q <= next_addr_d;
            if (ucnt_q != CNT_MAX) ucnt_q <= ucnt_q + DATAWIDTH_COUNTER'(1);
            if (is_decode && icnt_q != CNT_MAX) icnt_q <= icnt_q + DATAWIDTH_COUNTER'(1);
            // A halt request is honoured only as the sequencer lands on the fetch microinstruction.
            if (!MICRO_SEQUENCER_Run_In && next_addr_d == FETCH) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        ST_WAITMEM: begin
          if (MICRO_SEQUENCER_MemReady_In) state_q <= ST_RUN;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          addr_q  <= FETCH;
        end
      endcase
    end
  end

  assign MICRO_SEQUENCER_CSAddress_OutBus   = addr_q;
  assign MICRO_SEQUENCER_State_OutBus       = state_q;
  assign MICRO_SEQUENCER_Busy_Out           = busy_q;
  assign MICRO_SEQUENCER_uCycleCount_OutBus = ucnt_q;
  assign MICRO_SEQUENCER_InstrCount_OutBus  = icnt_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: a full-width instance and a 4-bit-counter instance share
// stimulus; a reference model queues expectations which a separate monitor checks after each edge.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, run, rd, wr, ready;
  logic [2:0]  cond;
  logic [10:0] jump;
  logic [3:0]  flags;
  logic [31:0] ir;

  logic [10:0] addr_a, addr_b;
  logic [1:0]  st_a, st_b;
  logic        busy_a, busy_b;
  logic [15:0] uc_a, ic_a;
  logic [3:0]  uc_b, ic_b;

  micro_sequencer dut_a (
    .MICRO_SEQUENCER_CLOCK_50          (clk),
    .MICRO_SEQUENCER_ResetInLow_In     (rst_n),
    .MICRO_SEQUENCER_Run_In            (run),
    .MICRO_SEQUENCER_Condition_InBus   (cond),
    .MICRO_SEQUENCER_JumpAddress_InBus (jump),
    .MICRO_SEQUENCER_RD_In             (rd),
    .MICRO_SEQUENCER_WR_In             (wr),
    .MICRO_SEQUENCER_MemReady_In       (ready),
    .MICRO_SEQUENCER_Flags_InBus       (flags),
    .MICRO_SEQUENCER_IR_InBus          (ir),
    .MICRO_SEQUENCER_CSAddress_OutBus  (addr_a),
    .MICRO_SEQUENCER_State_OutBus      (st_a),
    .MICRO_SEQUENCER_Busy_Out          (busy_a),
    .MICRO_SEQUENCER_uCycleCount_OutBus(uc_a),
    .MICRO_SEQUENCER_InstrCount_OutBus (ic_a)
  );

  // Narrow counters reach saturation within a few cycles.
  micro_sequencer #(.DATAWIDTH_COUNTER(4)) dut_b (
    .MICRO_SEQUENCER_CLOCK_50          (clk),
    .MICRO_SEQUENCER_ResetInLow_In     (rst_n),
    .MICRO_SEQUENCER_Run_In            (run),
    .MICRO_SEQUENCER_Condition_InBus   (cond),
    .MICRO_SEQUENCER_JumpAddress_InBus (jump),
    .MICRO_SEQUENCER_RD_In             (rd),
    .MICRO_SEQUENCER_WR_In             (wr),
    .MICRO_SEQUENCER_MemReady_In       (ready),
    .MICRO_SEQUENCER_Flags_InBus       (flags),
    .MICRO_SEQUENCER_IR_InBus          (ir),
    .MICRO_SEQUENCER_CSAddress_OutBus  (addr_b),
    .MICRO_SEQUENCER_State_OutBus      (st_b),
    .MICRO_SEQUENCER_Busy_Out          (busy_b),
    .MICRO_SEQUENCER_uCycleCount_OutBus(uc_b),
    .MICRO_SEQUENCER_InstrCount_OutBus (ic_b)
  );

  typedef struct {
    int addr;
    int state;
    int ucnt;
    int icnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: 0 idle, 1 run, 2 waiting on memory; counters kept unbounded.
  int m_state, m_addr, m_ucnt, m_icnt;

  function automatic int sat(int v, int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function void chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endfunction

  task automatic model_reset();
    m_state = 0; m_addr = 0; m_ucnt = 0; m_icnt = 0;
  endtask

  task automatic model_step(bit rn, int c, int j, bit rdv, bit wrv, bit rdy, bit [3:0] f, bit [31:0] i);
    int  nxt;
    bit  take;
    case (m_state)
      0: begin
        m_addr = 0;
        if (rn) m_state = 1;
      end
      1: begin
        if ((rdv || wrv) && !rdy) m_state = 2;
        else begin
          case (c)
            1: take = f[3];
            2: take = f[2];
            3: take = f[1];
            4: take = f[0];
            5: take = i[13];
            6: take = 1'b1;
            default: take = 1'b0;
          endcase
          if (c == 7) nxt = 1024 + int'(i[31:30]) * 256 + int'(i[24:19]) * 4;
          else if (take) nxt = j;
          else nxt = (m_addr + 1) % 2048;
          m_addr = nxt;
          m_ucnt++;
          if (c == 7) m_icnt++;
          if (!rn && nxt == 0) m_state = 0;
        end
      end
      default: if (rdy) m_state = 1;
    endcase
  endtask

  // One microcycle: drive MIR/status at the falling edge, predict the following rising edge.
  task automatic step(bit r, bit rn, bit [2:0] c, bit [10:0] j, bit rdv, bit wrv, bit rdy,
                      bit [3:0] f, bit [31:0] i);
    exp_t e;
    @(negedge clk);
    if (r) begin
      rst_n = 1'b0;
      #1;
      chk("rst_addr", int'(addr_a), 0);
      chk("rst_state", int'(st_a), 0);
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_ucnt", int'(uc_a), 0);
      chk("rst_icnt", int'(ic_a), 0);
      model_reset();
    end else begin
      rst_n = 1'b1;
    end
    run = rn; cond = c; jump = j; rd = rdv; wr = wrv; ready = rdy; flags = f; ir = i;
    if (!r) model_step(rn, int'(c), int'(j), rdv, wrv, rdy, f, i);
    e.addr = m_addr; e.state = m_state; e.ucnt = m_ucnt; e.icnt = m_icnt;
    sb_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("addr", int'(addr_a), e.addr);
        chk("state", int'(st_a), e.state);
        chk("busy", int'(busy_a), (e.state != 0) ? 1 : 0);
        chk("ucnt", int'(uc_a), sat(e.ucnt, 65535));
        chk("icnt", int'(ic_a), sat(e.icnt, 65535));
        chk("addr_n", int'(addr_b), e.addr);
        chk("state_n", int'(st_b), e.state);
        chk("busy_n", int'(busy_b), (e.state != 0) ? 1 : 0);
        chk("ucnt_sat", int'(uc_b), sat(e.ucnt, 15));
        chk("icnt_sat", int'(ic_b), sat(e.icnt, 15));
      end
    end
  end

  localparam bit [31:0] IR_ADDCC = 32'h8080_0000;

  initial begin : driver
    rst_n = 1'b0; run = 1'b0; cond = 3'd0; jump = 11'd0; rd = 1'b0; wr = 1'b0;
    ready = 1'b0; flags = 4'd0; ir = 32'd0;
    model_reset();

    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Start, NEXT, then DECODE of an ADDCC.
    step(0, 1, 3'd0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3'd0, 0, 0, 0, 0, 0, IR_ADDCC);
    step(0, 1, 3'd7, 0, 0, 0, 0, 0, IR_ADDCC);
    settle();
    chk("decode_addr", int'(addr_a), 1600);
    chk("decode_icnt", int'(ic_a), 1);

    // IR[13] branch taken, then not taken; z-branch with z=0 falls through.
    step(0, 1, 3'd5, 11'd1602, 0, 0, 0, 4'b1011, IR_ADDCC | 32'h2000);
    step(0, 1, 3'd5, 11'd5, 0, 0, 0, 4'b0000, IR_ADDCC);
    step(0, 1, 3'd2, 11'd5, 0, 0, 0, 4'b1011, 0);
    settle();
    chk("zbranch_addr", int'(addr_a), 1604);

    // Memory stall for three cycles with Run dropped; jump to fetch then halts.
    step(0, 1, 3'd6, 11'd0, 1, 0, 0, 0, 0);
    step(0, 0, 3'd6, 11'd0, 1, 0, 0, 4'hF, 0);
    step(0, 0, 3'd6, 11'd0, 1, 0, 0, 0, 0);
    settle();
    chk("wait_state", int'(st_a), 2);
    chk("wait_addr", int'(addr_a), 1604);
    step(0, 0, 3'd6, 11'd0, 1, 0, 1, 0, 0);
    step(0, 0, 3'd6, 11'd0, 1, 0, 1, 0, 0);
    settle();
    chk("halt_state", int'(st_a), 0);
    chk("halt_addr", int'(addr_a), 0);
    step(0, 0, 3'd6, 11'd9, 0, 0, 0, 0, 0);
    step(0, 0, 3'd6, 11'd9, 0, 0, 0, 0, 0);

    // Wrap at the top of the control store.
    step(0, 1, 3'd0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3'd6, 11'd2047, 0, 0, 0, 0, 0);
    step(0, 1, 3'd0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("wrap_addr", int'(addr_a), 0);

    // Asynchronous reset in the middle of a running program.
    step(0, 1, 3'd6, 11'd1601, 0, 0, 0, 0, 0);
    step(1, 1, 3'd0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      bit        r, rn, rdv, wrv, rdy;
      bit [10:0] j;
      r   = ($urandom_range(0, 199) == 0);
      rn  = ($urandom_range(0, 9) != 0);
      rdv = ($urandom_range(0, 3) == 0);
      wrv = ($urandom_range(0, 5) == 0);
      rdy = $urandom_range(0, 1) == 1;
      j   = ($urandom_range(0, 3) == 0) ? 11'd0 : 11'($urandom);
      step(r, rn, 3'($urandom), j, rdv, wrv, rdy, 4'($urandom), $urandom);
    end

    settle();
    settle();
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
